// File: rtl/joy_dir_filter_if.sv
// Joystick conditioner bus: mode/disable/raw directions in, filtered directions out.
// Combinational bundle only; no flow control, outputs are valid every cycle.
interface joy_dir_filter_if #(
    parameter int NUM_PLAYERS = 2
);
    logic [1:0]               mode;
    logic [NUM_PLAYERS-1:0]   dis;
    logic [4*NUM_PLAYERS-1:0] indir;
    logic [4*NUM_PLAYERS-1:0] outdir;

    modport master (
        output mode,
        output dis,
        output indir,
        input  outdir
    );

    modport slave (
        input  mode,
        input  dis,
        input  indir,
        output outdir
    );
endinterface

// File: rtl/joy_dir_filter.sv
// Per-player joystick synchroniser, optional debounce and direction policy (8/4/4/2-way).
// Latency SYNC_STAGES+1 cycles (+DEBOUNCE_CYCLES when enabled); no backpressure, output valid every cycle.
module joy_dir_filter #(
    parameter int NUM_PLAYERS     = 2,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic            clk,
    input  logic            reset,
    joy_dir_filter_if.slave jif
);

    localparam int NB = 4 * NUM_PLAYERS;
    localparam int CW = 16;

    localparam logic [1:0] MODE_8WAY  = 2'd0;
    localparam logic [1:0] MODE_LAST  = 2'd1;
    localparam logic [1:0] MODE_FIRST = 2'd2;
    localparam logic [1:0] MODE_2WAY  = 2'd3;

    // Priority up > down > left > right, bits ordered {up,down,left,right}.
    function automatic logic [3:0] hp(input logic [3:0] x);
        logic [3:0] r;
        r = 4'b0000;
        if (x[3])      r = 4'b1000;
        else if (x[2]) r = 4'b0100;
        else if (x[1]) r = 4'b0010;
        else if (x[0]) r = 4'b0001;
        return r;
    endfunction

    logic [NB-1:0] sync_q [SYNC_STAGES];
    logic [NB-1:0] s;
    logic [NB-1:0] d;
    logic [NB-1:0] dprev;
    logic [1:0]    mode_prev;
    logic          mode_chg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= jif.indir;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_no_debounce
            assign d = s;
        end else begin : g_debounce
            logic [CW-1:0] cnt [NB];
            logic [NB-1:0] d_q;

            // Counter only runs while the synchronised bit disagrees with the accepted value.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    d_q <= '0;
                    for (int b = 0; b < NB; b++) begin
                        cnt[b] <= '0;
                    end
                end else begin
                    for (int b = 0; b < NB; b++) begin
                        if (s[b] == d_q[b]) begin
                            cnt[b] <= '0;
                        end else if (cnt[b] == CW'(DEBOUNCE_CYCLES - 1)) begin
                            d_q[b] <= s[b];
                            cnt[b] <= '0;
                        end else begin
                            cnt[b] <= cnt[b] + 1'b1;
                        end
                    end
                end
            end

            assign d = d_q;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dprev     <= '0;
            mode_prev <= '0;
        end else begin
            dprev     <= d;
            mode_prev <= jif.mode;
        end
    end

    assign mode_chg = (jif.mode != mode_prev);

    generate
        for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
            logic [3:0] dp;
            logic [3:0] newp;
            logic [3:0] mask_q;
            logic [3:0] mask_n;
            logic [3:0] out_n;
            logic [3:0] out_q;

            assign dp   = d[4*p +: 4];
            assign newp = d[4*p +: 4] & ~dprev[4*p +: 4];

            always_comb begin
                mask_n = mask_q;
                out_n  = 4'b0000;

                case (jif.mode)
                    MODE_LAST: begin
                        if (newp != 4'b0000) begin
                            mask_n = hp(newp);
                        end else if ((dp & mask_q) == 4'b0000) begin
                            mask_n = hp(dp);
                        end
                    end
                    MODE_FIRST: begin
                        if ((dp & mask_q) == 4'b0000) begin
                            mask_n = hp(dp);
                        end
                    end
                    default: mask_n = 4'b0000;
                endcase

                // Disable or a policy switch restarts selection from scratch.
                if (jif.dis[p] || mode_chg) begin
                    mask_n = 4'b0000;
                end

                case (jif.mode)
                    MODE_8WAY:  out_n = {dp[3] & ~dp[2], dp[2] & ~dp[3],
                                         dp[1] & ~dp[0], dp[0] & ~dp[1]};
                    MODE_LAST,
                    MODE_FIRST: out_n = dp & mask_n;
                    MODE_2WAY:  out_n = {2'b00, dp[1] & ~dp[0], dp[0] & ~dp[1]};
                    default:    out_n = 4'b0000;
                endcase

                if (jif.dis[p]) begin
                    out_n = 4'b0000;
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    mask_q <= '0;
                    out_q  <= '0;
                end else begin
                    mask_q <= mask_n;
                    out_q  <= out_n;
                end
            end

            assign jif.outdir[4*p +: 4] = out_q;
        end
    endgenerate

endmodule

// File: tb/tb_joy_dir_filter.sv
// Directed bench for joy_dir_filter: two instances (no debounce / 4-cycle debounce) against a behavioural model.
module tb_joy_dir_filter;
    localparam int NP = 2;
    localparam int SS = 2;

    logic clk = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_pass = 0;

    joy_dir_filter_if #(.NUM_PLAYERS(NP)) j0 ();
    joy_dir_filter_if #(.NUM_PLAYERS(NP)) j1 ();

    joy_dir_filter #(.NUM_PLAYERS(NP), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(0)) u_nodeb (
        .clk   (clk),
        .reset (reset),
        .jif   (j0)
    );

    joy_dir_filter #(.NUM_PLAYERS(NP), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(4)) u_deb (
        .clk   (clk),
        .reset (reset),
        .jif   (j1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] hist[$];
    logic [7:0] m_d[2];
    logic [7:0] m_dprev[2];
    logic [7:0] m_out[2];
    int         m_run[2][8];
    int         m_sel[2][NP];
    logic [1:0] m_mode_prev;

    function automatic int top_dir(input logic [3:0] x);
        for (int b = 3; b >= 0; b--) if (x[b]) return b;
        return -1;
    endfunction

    function automatic logic [3:0] onehot(input int idx);
        logic [3:0] v;
        v = 4'b0000;
        if (idx >= 0) v[idx] = 1'b1;
        return v;
    endfunction

    task automatic model_clear();
        hist.delete();
        for (int k = 0; k < SS; k++) hist.push_back(8'h00);
        m_mode_prev = 2'd0;
        for (int i = 0; i < 2; i++) begin
            m_d[i] = 8'h00; m_dprev[i] = 8'h00; m_out[i] = 8'h00;
            for (int b = 0; b < 8; b++) m_run[i][b] = 0;
            for (int p = 0; p < NP; p++) m_sel[i][p] = -1;
        end
    endtask

    // Advance the model by one clock edge given the inputs seen at that edge.
    task automatic model_step(input logic [1:0] md, input logic [NP-1:0] ds, input logic [7:0] raw);
        logic [7:0] s_old, s_new, o;
        logic [3:0] dv, nw, op;
        int sel, deb;
        s_old = hist[0];
        hist.push_back(raw);
        void'(hist.pop_front());
        s_new = hist[0];
        for (int i = 0; i < 2; i++) begin
            deb = (i == 0) ? 0 : 4;
            o = 8'h00;
            for (int p = 0; p < NP; p++) begin
                dv  = m_d[i][4*p +: 4];
                nw  = dv & ~m_dprev[i][4*p +: 4];
                sel = m_sel[i][p];
                if (ds[p] || md != m_mode_prev) sel = -1;
                else if (md == 2'd1) begin
                    if (nw != 0) sel = top_dir(nw);
                    else if (sel < 0 || !dv[sel]) sel = top_dir(dv);
                end else if (md == 2'd2) begin
                    if (sel < 0 || !dv[sel]) sel = top_dir(dv);
                end else sel = -1;
                m_sel[i][p] = sel;
                // Opposing pairs cancel; 4-way modes show only the selected held direction.
                case (md)
                    2'd0: op = {dv[3] && !dv[2], dv[2] && !dv[3], dv[1] && !dv[0], dv[0] && !dv[1]};
                    2'd3: op = {1'b0, 1'b0, dv[1] && !dv[0], dv[0] && !dv[1]};
                    default: op = dv & onehot(sel);
                endcase
                if (ds[p]) op = 4'b0000;
                o[4*p +: 4] = op;
            end
            m_out[i]   = o;
            m_dprev[i] = m_d[i];
            if (deb == 0) m_d[i] = s_new;
            else begin
                for (int b = 0; b < 8; b++) begin
                    if (s_old[b] != m_d[i][b]) begin
                        m_run[i][b]++;
                        if (m_run[i][b] == deb) begin
                            m_d[i][b] = s_old[b];
                            m_run[i][b] = 0;
                        end
                    end else m_run[i][b] = 0;
                end
            end
        end
        m_mode_prev = md;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (reset) model_clear();
            chk("model_nodeb", j0.outdir, m_out[0]);
            chk("model_deb", j1.outdir, m_out[1]);
            if (!reset) model_step(j0.mode, j0.dis, j0.indir);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic set_in(input logic [1:0] md, input logic [NP-1:0] ds, input logic [7:0] dir);
        j0.mode = md; j0.dis = ds; j0.indir = dir;
        j1.mode = md; j1.dis = ds; j1.indir = dir;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        set_in(2'd1, 2'b00, 8'h00);
        step(2);
        reset = 1'b0;
        chk("reset_out", j0.outdir, 8'h00);

        // Last-pressed: right, then up added, fallback, release.
        set_in(2'd1, 2'b00, 8'h01);
        step(2); chk("lp_latency_early", j0.outdir, 8'h00);
        step(1); chk("lp_right", j0.outdir, 8'h01);
        step(9);
        set_in(2'd1, 2'b00, 8'h09);
        step(2); chk("lp_up_pending", j0.outdir, 8'h01);
        step(1); chk("lp_up_wins", j0.outdir, 8'h08);
        set_in(2'd1, 2'b00, 8'h01);
        step(3); chk("lp_fallback", j0.outdir, 8'h01);
        set_in(2'd1, 2'b00, 8'h00);
        step(3); chk("lp_release", j0.outdir, 8'h00);

        // First-held: left stays while down joins.
        set_in(2'd2, 2'b00, 8'h00);
        step(2);
        set_in(2'd2, 2'b00, 8'h02);
        step(3); chk("fh_left", j0.outdir, 8'h02);
        set_in(2'd2, 2'b00, 8'h06);
        step(5); chk("fh_hold_left", j0.outdir, 8'h02);
        set_in(2'd2, 2'b00, 8'h04);
        step(3); chk("fh_down_after", j0.outdir, 8'h04);

        // Simultaneous presses and 8-way cancel.
        set_in(2'd1, 2'b00, 8'h00);
        step(4);
        set_in(2'd1, 2'b00, 8'h0A);
        step(3); chk("lp_simul", j0.outdir, 8'h08);
        set_in(2'd0, 2'b00, 8'h0D);
        step(3); chk("m0_ud_cancel", j0.outdir, 8'h01);
        set_in(2'd0, 2'b00, 8'h0A);
        step(3); chk("m0_diag", j0.outdir, 8'h0A);

        // 2-way on player 1.
        set_in(2'd3, 2'b00, 8'hE0);
        step(3); chk("m3_p1_left", j0.outdir, 8'h20);
        set_in(2'd3, 2'b00, 8'h30);
        step(3); chk("m3_p1_lr_cancel", j0.outdir, 8'h00);

        // Debounce: short pulse rejected, 4-cycle pulse accepted after 2+4+1.
        set_in(2'd0, 2'b00, 8'h00);
        step(12);
        set_in(2'd0, 2'b00, 8'h01);
        step(3);
        set_in(2'd0, 2'b00, 8'h00);
        for (int k = 0; k < 8; k++) begin
            step(1); chk("deb_short", j1.outdir, 8'h00);
        end
        set_in(2'd0, 2'b00, 8'h01);
        step(4);
        set_in(2'd0, 2'b00, 8'h00);
        step(2); chk("deb_long_early", j1.outdir, 8'h00);
        step(1); chk("deb_long", j1.outdir, 8'h01);
        step(8);

        // Disable then fallback, mode switch, async reset.
        set_in(2'd1, 2'b00, 8'h01);
        step(12); chk("dis_pre", j0.outdir, 8'h01);
        set_in(2'd1, 2'b01, 8'h01);
        for (int k = 0; k < 5; k++) begin
            step(1); chk("dis_active", j0.outdir, 8'h00);
        end
        set_in(2'd1, 2'b00, 8'h01);
        step(1); chk("dis_fallback", j0.outdir, 8'h01);
        set_in(2'd2, 2'b00, 8'h01);
        step(1); chk("modechg_clear", j0.outdir, 8'h00);
        step(1); chk("mode2_reacquire", j0.outdir, 8'h01);
        step(3); chk("deb_hold_pre_reset", j1.outdir, 8'h01);
        #3 reset = 1'b1;
        #1 chk("async_reset_nodeb", j0.outdir, 8'h00);
        chk("async_reset_deb", j1.outdir, 8'h00);
        @(posedge clk); #1 reset = 1'b0;
        step(2); chk("post_reset_early", j0.outdir, 8'h00);
        step(1); chk("post_reset_out", j0.outdir, 8'h01);
        step(4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
